// File: rtl/djs_zt_sequencer.sv
// DJS-130 machine-cycle sequencer: walks the fetch/indirect/execute/interrupt/
// data-channel/console cycles and emits the load strobes for the state block.
module djs_zt_sequencer #(
    parameter int BEATS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_dep,
    input  logic       i_halt,
    input  logic       i_ind,
    input  logic       i_int_req,
    input  logic       i_int_en,
    input  logic       i_dch_req,
    input  logic       i_mem_rdy,
    output logic [2:0] o_beat,
    output logic       o_DRJsz,
    output logic       o_DRJz,
    output logic       o_DRJcx,
    output logic       o_DRJd,
    output logic       o_DRZT,
    output logic       o_DRYX,
    output logic       o_Z0YX,
    output logic       o_1_YX,
    output logic       o_1_QZZT,
    output logic       o_1_JZZT,
    output logic       o_1_ZXZT,
    output logic       o_1_ZDZT,
    output logic       o_1_STDZT,
    output logic       o_1_KTZT,
    output logic       o_1_KTCZZT
);

    typedef enum logic [2:0] {
        S_KT   = 3'd0,
        S_QZ   = 3'd1,
        S_JZ   = 3'd2,
        S_ZX   = 3'd3,
        S_ZD   = 3'd4,
        S_STD  = 3'd5,
        S_KTCZ = 3'd6
    } state_t;

    localparam logic [2:0] L_BEAT = 3'(BEATS - 1);

    // Bit position of the one-hot equals the state encoding.
    function automatic logic [6:0] f_onehot(input state_t s);
        f_onehot = 7'd1 << s;
    endfunction

    state_t     r_state, r_saved, w_state_n, w_saved_n, w_nat;
    logic [2:0] r_beat, w_beat_n;
    logic       r_run, w_run_n, r_stop_pend, w_stop_n;
    logic [6:0] r_dec, w_dec_n;
    logic       w_last, w_stall, w_mem_state;
    logic       w_jsz, w_jz, w_jcx, w_jd, w_zt, w_yx, w_z0, w_1yx;

    assign w_last      = (r_beat == L_BEAT);
    assign w_mem_state = (r_state == S_QZ) || (r_state == S_JZ) ||
                         (r_state == S_STD) || (r_state == S_KTCZ);
    assign w_stall     = w_mem_state && (r_beat == 3'd1) && !i_mem_rdy;

    // Natural successor of the current cycle, ignoring halt/stop and data channel.
    always_comb begin
        w_nat = S_KT;
        case (r_state)
            S_QZ:    w_nat = i_ind ? S_JZ : S_ZX;
            S_JZ:    w_nat = i_ind ? S_JZ : S_ZX;
            S_ZX:    w_nat = (i_int_req && i_int_en) ? S_ZD : S_QZ;
            S_ZD:    w_nat = S_QZ;
            S_STD:   w_nat = r_saved;
            S_KTCZ:  w_nat = S_KT;
            default: w_nat = S_KT;
        endcase
    end

    // Beat/state advance, strobe decode and next-state decision.
    always_comb begin
        w_state_n = r_state;
        w_beat_n  = r_beat;
        w_run_n   = r_run;
        w_stop_n  = r_stop_pend | (r_run & i_stop);
        w_saved_n = r_saved;
        w_dec_n   = r_dec;
        w_jsz = 1'b0; w_jz = 1'b0; w_jcx = 1'b0; w_jd = 1'b0;
        w_zt  = 1'b0; w_yx = 1'b0; w_z0  = 1'b0; w_1yx = 1'b0;
        if (r_state == S_KT) begin
            w_beat_n = 3'd0;
            if (!r_run && !i_stop && i_start) begin
                w_run_n   = 1'b1;
                w_yx      = 1'b1;
                w_1yx     = 1'b1;
                w_zt      = 1'b1;
                w_state_n = S_QZ;
                w_dec_n   = f_onehot(S_QZ);
            end else if (!r_run && !i_stop && i_dep) begin
                w_zt      = 1'b1;
                w_state_n = S_KTCZ;
                w_dec_n   = f_onehot(S_KTCZ);
            end else begin
                w_state_n = S_KT;
            end
        end else begin
            if (w_stall) begin
                w_beat_n = r_beat;
            end else if (w_last) begin
                w_beat_n = 3'd0;
            end else begin
                w_beat_n = r_beat + 3'd1;
            end
            case (r_beat)
                3'd0: begin
                    w_jd  = (r_state == S_QZ) || (r_state == S_STD) || (r_state == S_KTCZ);
                    w_jsz = (r_state == S_ZD);
                end
                3'd1:    w_jcx = w_mem_state && i_mem_rdy;
                3'd2:    w_jz  = (r_state == S_QZ);
                default: w_jz  = 1'b0;
            endcase
            if (w_last) begin
                w_zt = 1'b1;
                if (r_state == S_QZ) begin
                    w_jsz = 1'b1;
                end else if (r_state == S_JZ) begin
                    w_jd = 1'b1;
                end else begin
                    w_jd = w_jd;
                end
                if ((r_state == S_ZX) && (i_halt || r_stop_pend)) begin
                    w_state_n = S_KT;
                    w_z0      = 1'b1;
                    w_run_n   = 1'b0;
                    w_stop_n  = 1'b0;
                end else if (i_dch_req && (r_state != S_STD) && (r_state != S_KTCZ)) begin
                    w_state_n = S_STD;
                    w_saved_n = w_nat;
                end else begin
                    w_state_n = w_nat;
                end
                w_dec_n = f_onehot(w_state_n);
            end else begin
                w_state_n = r_state;
            end
        end
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_KT;
            r_saved     <= S_QZ;
            r_beat      <= 3'd0;
            r_run       <= 1'b0;
            r_stop_pend <= 1'b0;
            r_dec       <= 7'b0000001;
            o_beat      <= 3'd0;
            o_DRJsz     <= 1'b0;
            o_DRJz      <= 1'b0;
            o_DRJcx     <= 1'b0;
            o_DRJd      <= 1'b0;
            o_DRZT      <= 1'b0;
            o_DRYX      <= 1'b0;
            o_Z0YX      <= 1'b0;
            o_1_YX      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_saved     <= w_saved_n;
            r_beat      <= w_beat_n;
            r_run       <= w_run_n;
            r_stop_pend <= w_stop_n;
            r_dec       <= w_dec_n;
            o_beat      <= r_beat;
            o_DRJsz     <= w_jsz;
            o_DRJz      <= w_jz;
            o_DRJcx     <= w_jcx;
            o_DRJd      <= w_jd;
            o_DRZT      <= w_zt;
            o_DRYX      <= w_yx;
            o_Z0YX      <= w_z0;
            o_1_YX      <= w_1yx;
        end
    end

    assign o_1_KTZT   = r_dec[0];
    assign o_1_QZZT   = r_dec[1];
    assign o_1_JZZT   = r_dec[2];
    assign o_1_ZXZT   = r_dec[3];
    assign o_1_ZDZT   = r_dec[4];
    assign o_1_STDZT  = r_dec[5];
    assign o_1_KTCZZT = r_dec[6];

endmodule

// File: tb/tb_djs_zt_sequencer.sv
// Directed bench for djs_zt_sequencer with BEATS=4; each output beat is
// checked against a hand-written strobe and next-state pattern.
module tb_djs_zt_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0, i_stop = 1'b0, i_dep = 1'b0, i_halt = 1'b0;
    logic       i_ind = 1'b0, i_int_req = 1'b0, i_int_en = 1'b0;
    logic       i_dch_req = 1'b0, i_mem_rdy = 1'b1;
    logic [2:0] o_beat;
    logic       o_DRJsz, o_DRJz, o_DRJcx, o_DRJd, o_DRZT, o_DRYX, o_Z0YX, o_1_YX;
    logic       o_1_QZZT, o_1_JZZT, o_1_ZXZT, o_1_ZDZT, o_1_STDZT, o_1_KTZT, o_1_KTCZZT;

    int total = 0;
    int bad   = 0;

    localparam logic [7:0] SZ = 8'h80, JZB = 8'h40, CX = 8'h20, JD = 8'h10;
    localparam logic [7:0] ZT = 8'h08, YX = 8'h04, Z0 = 8'h02, Y1 = 8'h01;
    localparam logic [7:0] NO = 8'h00;
    localparam logic [6:0] N_KT = 7'h01, N_QZ = 7'h02, N_JZ = 7'h04, N_ZX = 7'h08;
    localparam logic [6:0] N_ZD = 7'h10, N_STD = 7'h20, N_KTCZ = 7'h40;

    wire [7:0] strb = {o_DRJsz, o_DRJz, o_DRJcx, o_DRJd, o_DRZT, o_DRYX, o_Z0YX, o_1_YX};
    wire [6:0] nxt  = {o_1_KTCZZT, o_1_STDZT, o_1_ZDZT, o_1_ZXZT, o_1_JZZT, o_1_QZZT, o_1_KTZT};

    djs_zt_sequencer #(.BEATS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_start(i_start), .i_stop(i_stop), .i_dep(i_dep), .i_halt(i_halt),
        .i_ind(i_ind), .i_int_req(i_int_req), .i_int_en(i_int_en),
        .i_dch_req(i_dch_req), .i_mem_rdy(i_mem_rdy),
        .o_beat(o_beat),
        .o_DRJsz(o_DRJsz), .o_DRJz(o_DRJz), .o_DRJcx(o_DRJcx), .o_DRJd(o_DRJd),
        .o_DRZT(o_DRZT), .o_DRYX(o_DRYX), .o_Z0YX(o_Z0YX), .o_1_YX(o_1_YX),
        .o_1_QZZT(o_1_QZZT), .o_1_JZZT(o_1_JZZT), .o_1_ZXZT(o_1_ZXZT),
        .o_1_ZDZT(o_1_ZDZT), .o_1_STDZT(o_1_STDZT), .o_1_KTZT(o_1_KTZT),
        .o_1_KTCZZT(o_1_KTCZZT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bt(input string tag, input logic [2:0] b, input logic [7:0] s);
        step();
        chk({tag, "_beat"}, 32'(o_beat), 32'(b));
        chk({tag, "_strb"}, 32'(strb), 32'(s));
    endtask

    task automatic cyc4(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] s2, input logic [7:0] s3, input logic [6:0] n);
        bt({tag, "0"}, 3'd0, s0);
        bt({tag, "1"}, 3'd1, s1);
        bt({tag, "2"}, 3'd2, s2);
        bt({tag, "3"}, 3'd3, s3);
        chk({tag, "_next"}, 32'(nxt), 32'(n));
    endtask

    initial begin
        #12;
        chk("rst_beat", 32'(o_beat), 32'd0);
        chk("rst_strb", 32'(strb), 32'd0);
        chk("rst_next", 32'(nxt), 32'(N_KT));
        step();
        rst_n = 1'b1;
        bt("kt_idle", 3'd0, NO);

        // start together with deposit: start wins
        i_start = 1'b1; i_dep = 1'b1;
        bt("start", 3'd0, YX | ZT | Y1);
        chk("start_next", 32'(nxt), 32'(N_QZ));
        i_start = 1'b0; i_dep = 1'b0;

        cyc4("qz1_", JD, CX, JZB, SZ | ZT, N_ZX);
        i_int_req = 1'b1; i_int_en = 1'b1;
        cyc4("zx1_", NO, NO, NO, ZT, N_ZD);
        i_int_req = 1'b0; i_int_en = 1'b0;
        cyc4("zd1_", SZ, NO, NO, ZT, N_QZ);

        // indirect chain; start/deposit while running are ignored
        i_ind = 1'b1; i_start = 1'b1; i_dep = 1'b1;
        cyc4("qz2_", JD, CX, JZB, SZ | ZT, N_JZ);
        i_start = 1'b0; i_dep = 1'b0;
        cyc4("jz1_", NO, CX, NO, JD | ZT, N_JZ);
        i_ind = 1'b0;
        cyc4("jz2_", NO, CX, NO, JD | ZT, N_ZX);
        i_int_req = 1'b1;
        cyc4("zx2_", NO, NO, NO, ZT, N_QZ);
        i_int_req = 1'b0;

        // memory stall at beat 1 for three clocks
        bt("stl0", 3'd0, JD);
        i_mem_rdy = 1'b0;
        for (int k = 0; k < 3; k++) bt("stl_hold", 3'd1, NO);
        i_mem_rdy = 1'b1;
        bt("stl1", 3'd1, CX);
        bt("stl2", 3'd2, JZB);
        bt("stl3", 3'd3, SZ | ZT);
        chk("stl_next", 32'(nxt), 32'(N_ZX));
        cyc4("zx3_", NO, NO, NO, ZT, N_QZ);

        // data channel steals the cycle after an indirect QZ, then JZ resumes
        i_ind = 1'b1; i_dch_req = 1'b1;
        cyc4("qz3_", JD, CX, JZB, SZ | ZT, N_STD);
        i_dch_req = 1'b0; i_ind = 1'b0;
        cyc4("std_", JD, CX, NO, ZT, N_JZ);
        cyc4("jz3_", NO, CX, NO, JD | ZT, N_ZX);
        cyc4("zx4_", NO, NO, NO, ZT, N_QZ);

        // stop mid-QZ is honoured only at the ZX boundary
        bt("sqz0", 3'd0, JD);
        i_stop = 1'b1;
        bt("sqz1", 3'd1, CX);
        i_stop = 1'b0;
        bt("sqz2", 3'd2, JZB);
        bt("sqz3", 3'd3, SZ | ZT);
        cyc4("szx_", NO, NO, NO, ZT | Z0, N_KT);
        bt("kt_hold0", 3'd0, NO);
        bt("kt_hold1", 3'd0, NO);
        chk("kt_hold_next", 32'(nxt), 32'(N_KT));

        i_dep = 1'b1;
        bt("dep", 3'd0, ZT);
        chk("dep_next", 32'(nxt), 32'(N_KTCZ));
        i_dep = 1'b0;
        cyc4("ktcz_", JD, CX, NO, ZT, N_KT);
        bt("kt_after_dep", 3'd0, NO);

        // stop beats start in KT
        i_start = 1'b1; i_stop = 1'b1;
        bt("stop_start", 3'd0, NO);
        i_start = 1'b0; i_stop = 1'b0;
        bt("still_kt", 3'd0, NO);
        chk("still_kt_next", 32'(nxt), 32'(N_KT));

        // HALT ends the run at the ZX boundary
        i_start = 1'b1;
        bt("start2", 3'd0, YX | ZT | Y1);
        i_start = 1'b0;
        cyc4("qz4_", JD, CX, JZB, SZ | ZT, N_ZX);
        i_halt = 1'b1;
        cyc4("hzx_", NO, NO, NO, ZT | Z0, N_KT);
        i_halt = 1'b0;
        bt("halt_kt", 3'd0, NO);

        // asynchronous reset in the middle of a QZ cycle
        i_start = 1'b1;
        bt("start3", 3'd0, YX | ZT | Y1);
        i_start = 1'b0;
        bt("mqz0", 3'd0, JD);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_beat", 32'(o_beat), 32'd0);
        chk("mrst_strb", 32'(strb), 32'd0);
        chk("mrst_next", 32'(nxt), 32'(N_KT));
        #3 rst_n = 1'b1;
        bt("mrst_idle", 3'd0, NO);
        chk("mrst_idle_next", 32'(nxt), 32'(N_KT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
